// File: rtl/seg_dynamic_scan.sv
// Six-digit multiplexed 7-segment scan controller with frame-aligned commit.
// Optional leading-zero blanking: define SEG_LZ_BLANK_EN.
module seg_dynamic_scan #(
  parameter logic [15:0] CNT_SCAN_MAX = 16'd49_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [23:0] data,
  input  logic [5:0]  point,
  input  logic        data_valid,
  input  logic        seg_en,
  output logic        busy,
  output logic        frame_done,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  logic [15:0] cnt_scan;
  logic        scan_flag;
  logic [2:0]  idx;
  logic [23:0] pend_data, act_data;
  logic [5:0]  pend_point, act_point;
  logic        boundary;
  logic [3:0]  nib;
  logic        dp;
  logic [6:0]  hex;
  logic        blank;
  logic [7:0]  seg_nxt;

  assign boundary = scan_flag && (idx == 3'd5);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_scan  <= '0;
      scan_flag <= 1'b0;
    end else begin
      cnt_scan  <= (cnt_scan == CNT_SCAN_MAX) ? 16'd0 : cnt_scan + 16'd1;
      scan_flag <= (cnt_scan == CNT_SCAN_MAX - 16'd1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (scan_flag)
        idx <= boundary ? 3'd0 : idx + 3'd1;
    end
  end

  // A load on the boundary cycle bypasses pending and lands in active.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pend_data  <= '0;
      pend_point <= '0;
      act_data   <= '0;
      act_point  <= '0;
      busy       <= 1'b0;
    end else if (boundary) begin
      busy <= 1'b0;
      if (data_valid) begin
        act_data  <= data;
        act_point <= point;
      end else if (busy) begin
        act_data  <= pend_data;
        act_point <= pend_point;
      end
    end else if (data_valid) begin
      pend_data  <= data;
      pend_point <= point;
      busy       <= 1'b1;
    end
  end

  always_comb begin
    nib = act_data[3:0];
    dp  = act_point[0];
    case (idx)
      3'd1: begin nib = act_data[7:4];   dp = act_point[1]; end
      3'd2: begin nib = act_data[11:8];  dp = act_point[2]; end
      3'd3: begin nib = act_data[15:12]; dp = act_point[3]; end
      3'd4: begin nib = act_data[19:16]; dp = act_point[4]; end
      3'd5: begin nib = act_data[23:20]; dp = act_point[5]; end
      default: ;
    endcase
  end

  always_comb begin
    hex = 7'h40;
    case (nib)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      4'hF: hex = 7'h0E;
      default: ;
    endcase
  end

`ifdef SEG_LZ_BLANK_EN
  logic [2:0] lz_top;

  // Digit 0 is never above lz_top, so it is never blanked.
  always_comb begin
    lz_top = 3'd0;
    for (int i = 0; i < 6; i++)
      if (act_data[i*4 +: 4] != 4'h0)
        lz_top = 3'(i);
  end

  assign blank = (idx > lz_top);
`else
  assign blank = 1'b0;
`endif

  assign seg_nxt = blank ? {~dp, 7'h7F} : {~dp, hex};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sel <= '0;
      seg <= 8'hFF;
    end else if (seg_en) begin
      sel <= 6'b000001 << idx;
      seg <= seg_nxt;
    end else begin
      sel <= '0;
      seg <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_seg_dynamic_scan.sv
// Self-checking bench for seg_dynamic_scan (CNT_SCAN_MAX=9, 60-cycle frames).
// Reference model works from absolute edge counts since reset.
module tb_seg_dynamic_scan;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [23:0] data = '0;
  logic [5:0]  point = '0;
  logic        data_valid = 1'b0;
  logic        seg_en = 1'b1;
  logic        busy, frame_done;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int checks = 0;
  int failures = 0;
  int n = 0;
  logic en_cur = 1'b1;
  int          wr_e[$];
  logic [29:0] wr_v[$];

  logic [7:0] hex_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  seg_dynamic_scan #(.CNT_SCAN_MAX(16'd9)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .data       (data),
    .point      (point),
    .data_valid (data_valid),
    .seg_en     (seg_en),
    .busy       (busy),
    .frame_done (frame_done),
    .sel        (sel),
    .seg        (seg)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
    end
  endtask

  // Writes take effect at the last frame boundary (edge multiple of 60).
  function automatic logic [29:0] active_at(input int k);
    int b = (k / 60) * 60;
    logic [29:0] v = '0;
    foreach (wr_e[i])
      if (b > 0 && wr_e[i] <= b) v = wr_v[i];
    return v;
  endfunction

  function automatic logic busy_at(input int k);
    int b = (k / 60) * 60;
    return (wr_e.size() > 0) && (wr_e[wr_e.size()-1] > b);
  endfunction

  function automatic logic [7:0] digit_pat(input logic [29:0] a,
                                           input int d);
    logic [23:0] dd = a[29:6];
    logic [5:0]  pp = a[5:0];
    logic [7:0]  r;
    int m = 0;
    for (int i = 0; i < 6; i++)
      if (dd[i*4 +: 4] != 4'h0) m = i;
    r = hex_tab[dd[d*4 +: 4]];
`ifdef SEG_LZ_BLANK_EN
    if (d > m) r = 8'hFF;
`endif
    if (pp[d]) r[7] = 1'b0;
    return r;
  endfunction

  task automatic check_now();
    int k = n - 1;
    int d = (k / 10) % 6;
    logic [5:0] es;
    logic [7:0] eg;
    if (n == 0) begin
      es = 6'b0;
      eg = 8'hFF;
    end else if (en_cur) begin
      es = 6'b1 << d;
      eg = digit_pat(active_at(k), d);
    end else begin
      es = 6'b0;
      eg = 8'hFF;
    end
    chk("sel", 32'(sel), 32'(es));
    chk("seg", 32'(seg), 32'(eg));
    chk("busy", 32'(busy), 32'(busy_at(n)));
    chk("frame_done", 32'(frame_done), 32'(n > 0 && n % 60 == 0));
  endtask

  task automatic cyc(input logic dv, input logic [23:0] d,
                     input logic [5:0] p, input logic en);
    data = d;
    point = p;
    data_valid = dv;
    seg_en = en;
    @(posedge sys_clk);
    n++;
    en_cur = en;
    if (dv) begin
      wr_e.push_back(n);
      wr_v.push_back({d, p});
    end
    @(negedge sys_clk);
    data_valid = 1'b0;
    check_now();
  endtask

  task automatic idle(input int c);
    for (int i = 0; i < c; i++) cyc(1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    #12;
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_fd", 32'(frame_done), 32'h0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    idle(130);

    cyc(1'b1, 24'h123456, 6'b000100, 1'b1);
    idle(100);

    cyc(1'b1, 24'hAAAAAA, 6'b0, 1'b1);
    idle(5);
    cyc(1'b1, 24'hBBBBBB, 6'b0, 1'b1);
    idle(80);

    cyc(1'b1, 24'h111111, 6'b111111, 1'b1);
    while ((n + 1) % 60 != 0) idle(1);
    cyc(1'b1, 24'hFFFFFF, 6'b0, 1'b1);
    idle(70);

    idle(33);
    for (int i = 0; i < 25; i++) cyc(1'b0, '0, '0, 1'b0);
    idle(40);

    cyc(1'b1, 24'h000042, 6'b0, 1'b1);
    idle(130);
    cyc(1'b1, 24'h000000, 6'b0, 1'b1);
    idle(130);
    cyc(1'b1, 24'h000000, 6'b100001, 1'b1);
    idle(130);

    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 19) == 0, 24'($urandom), 6'($urandom),
          $urandom_range(0, 7) != 0);

    cyc(1'b1, 24'h987654, 6'b0, 1'b1);
    idle(3);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", 32'(sel), 32'h0);
    chk("mid_rst_seg", 32'(seg), 32'hFF);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_fd", 32'(frame_done), 32'h0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    n = 0;
    en_cur = 1'b1;
    wr_e.delete();
    wr_v.delete();
    idle(130);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
